mac_dot_engine: RTL and testbench
=================================

Name: mac_dot_engine

Overview:
- Parametrised, handshaked signed multiply-accumulate engine for the conv and FC layers.
- Computes bias + sum of a[i]*b[i] over a runtime-programmable length per job.
- Applies arithmetic right shift with rounding, then saturates to the output width.
- Replaces hard-coded per-layer counts (25 / 192) with a per-job length, and decouples producer and consumer with valid/ready.

Parameters:
- DATA_W, 16, signed operand width of a, b and bias
- ACC_W, 48, internal accumulator width; must be >= 2*DATA_W
- LEN_W, 10, width of the job length field (max 1023 products)
- OUT_W, 32, signed result width; must be <= ACC_W
- SHIFT_W, 6, width of the shift amount

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  job start, sampled only in IDLE
- len  in  LEN_W  products in job, latched on start
- bias  in  DATA_W  signed bias, latched on start
- shift  in  SHIFT_W  right-shift amount, latched on start
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts operand beat
- a  in  DATA_W  signed operand
- b  in  DATA_W  signed operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  signed result
- out_sat  out  1  result was clipped; qualified by out_valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Flops change only on the rising edge of clk.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0, accumulator=0, counter=0, product-valid=0.
- States: IDLE, ACC, DRAIN, OUT.
- IDLE:
  - On start=1, latch len, shift and bias; load the accumulator with bias sign-extended to ACC_W.
  - If len!=0, go to ACC with remaining=len.
  - If len==0, go to DRAIN.
- ACC:
  - in_ready=1. A beat is accepted when in_valid & in_ready.
  - Each accepted a*b (full 2*DATA_W signed product) is registered, then added to the accumulator the next cycle, sign-extended to ACC_W.
  - The product pipeline is one stage.
  - remaining decrements per accepted beat. On the beat making remaining 0, go to DRAIN.
  - Cycles with in_valid=0 are bubbles: the accumulator holds and no count is taken.
- DRAIN: in_ready=0. Stay one cycle so the final product is added, then go to OUT.
- OUT:
  - Result is computed from the final accumulator and registered with out_valid=1.
  - out_data and out_sat hold stable until out_valid & out_ready.
  - On that handshake, drop out_valid and go to IDLE.
  - A new start is sampled no earlier than the following cycle.
- Latency: last beat accepted at cycle t, out_valid=1 at t+3. For len==0, start at t gives out_valid at t+2.
- Arithmetic:
  - Accumulator wraps modulo 2^ACC_W; there is no internal saturation.
  - Rounding: for shift>0, add 2^(shift-1) before an arithmetic right shift by shift. For shift=0, no rounding.
  - shift >= ACC_W yields 0 for non-negative values and -1 for negative values.
  - Saturation: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 when clipped.
- start outside IDLE is ignored.
- in_valid outside ACC is ignored, with no state change.
- reset mid-job (any state) aborts: partial sum is discarded and all reset values are reapplied the next edge.

Optional Feature:
- MAC_DOT_RELU_EN defined:
  - Adds input port relu (1 bit), latched on start.
  - When the latched relu=1, a negative saturated result is replaced by 0. out_sat still reflects the saturation step only.
- Undefined: port absent; the result is the saturated value unmodified.

Decomposition:
- Shared package mac_pkg:
  - state enum mac_state_t {IDLE, ACC, DRAIN, OUT}
  - default width constants for DATA_W, ACC_W, OUT_W
  - layer length constants CONV_LEN=25, FC_LEN=192
- One sub-module, mac_round_sat: combinational rounding shift and saturation, parameterised by ACC_W, OUT_W and SHIFT_W. Outputs the value and the sat flag.

Test Plan:
- Conv job: len=25, bias=0, shift=0, all beats a=2, b=3, back-to-back -> out_data=150, out_sat=0, out_valid 3 cycles after the 25th beat.
- FC job with bubbles: len=192, bias=-100, shift=0, a=1, b=1, in_valid toggled every other cycle -> out_data=92; in_ready low in IDLE, DRAIN and OUT.
- Rounding: len=1, a=7, b=1, bias=0, shift=1 -> out_data=4. Then a=-7, shift=1 -> out_data=-3.
- Saturation with OUT_W=16: len=4, a=b=32767 -> out_data=32767, out_sat=1. Then a=-32768, b=32767 -> out_data=-32768, out_sat=1.
- Backpressure and len=0: len=0, bias=5, out_ready held low 10 cycles -> out_data=5 stable throughout; a start pulse during OUT is ignored.
- Reset mid-ACC after 10 of 25 beats, then a new job len=2, a=b=1 -> out_data=2; with MAC_DOT_RELU_EN and relu=1, a=-3, b=1 -> out_data=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate dot-product engine.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mac_state_t;

  localparam int MAC_DATA_W  = 16;
  localparam int MAC_ACC_W   = 48;
  localparam int MAC_OUT_W   = 32;
  localparam int MAC_LEN_W   = 10;
  localparam int MAC_SHIFT_W = 6;

  localparam int CONV_LEN = 25;
  localparam int FC_LEN   = 192;

endpackage

// File: rtl/mac_round_sat.sv
// Combinational rounding arithmetic right shift followed by clip to the signed
// output range; o_sat flags that the clip was applied.
module mac_round_sat
  import mac_pkg::*;
#(
  parameter int ACC_W   = MAC_ACC_W,
  parameter int OUT_W   = MAC_OUT_W,
  parameter int SHIFT_W = MAC_SHIFT_W
) (
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic        [SHIFT_W-1:0] i_shift,
  output logic signed [OUT_W-1:0]   o_data,
  output logic                      o_sat
);

  // One guard bit so adding the rounding half cannot overflow.
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_half;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_shr;
  logic                  w_big;

  always_comb begin
    w_ext  = (ACC_W+1)'(i_acc);
    w_half = '0;
    if (i_shift != '0) w_half = (ACC_W+1)'(1) << (i_shift - SHIFT_W'(1));
    w_rnd  = w_ext + w_half;
    w_shr  = w_rnd >>> i_shift;
    w_big  = {{(32-SHIFT_W){1'b0}}, i_shift} >= ACC_W;
    if (w_big) w_shr = i_acc[ACC_W-1] ? '1 : '0;

    o_sat  = 1'b0;
    o_data = w_shr[OUT_W-1:0];
    if (w_shr > MAX_V) begin
      o_sat  = 1'b1;
      o_data = MAX_V[OUT_W-1:0];
    end else if (w_shr < MIN_V) begin
      o_sat  = 1'b1;
      o_data = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mac_dot_engine.sv
// Handshaked signed MAC engine: bias + sum(a*b) over a per-job length, then round,
// shift and saturate. Optional ReLU on the result when MAC_DOT_RELU_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; job parameters latched on start
// ACC   | accepting operand beats, one registered product per beat
// DRAIN | last product folds into the accumulator
// OUT   | result held until the consumer takes it
module mac_dot_engine
  import mac_pkg::*;
#(
  parameter int DATA_W  = MAC_DATA_W,
  parameter int ACC_W   = MAC_ACC_W,
  parameter int LEN_W   = MAC_LEN_W,
  parameter int OUT_W   = MAC_OUT_W,
  parameter int SHIFT_W = MAC_SHIFT_W
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic        [LEN_W-1:0]   i_len,
  input  logic signed [DATA_W-1:0]  i_bias,
  input  logic        [SHIFT_W-1:0] i_shift,
`ifdef MAC_DOT_RELU_EN
  input  logic                      i_relu,
`endif
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic signed [DATA_W-1:0]  i_a,
  input  logic signed [DATA_W-1:0]  i_b,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic signed [OUT_W-1:0]   o_out_data,
  output logic                      o_out_sat,
  output logic                      o_busy
);

  localparam int PROD_W = 2 * DATA_W;

  mac_state_t r_state, w_state_next;

  logic signed [ACC_W-1:0]  r_acc;
  logic        [LEN_W-1:0]  r_remaining;
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_prod_vld;
  logic        [SHIFT_W-1:0] r_shift;
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_out_sat;

  logic                     w_start_job;
  logic                     w_beat;
  logic                     w_load_out;
  logic                     w_out_fire;
  logic signed [OUT_W-1:0]  w_sat_data;
  logic signed [OUT_W-1:0]  w_res_data;
  logic                     w_sat;

  assign w_start_job = (r_state == IDLE) && i_start;
  assign w_beat      = (r_state == ACC) && i_in_valid;
  assign w_out_fire  = r_out_valid && i_out_ready;
  // An empty job has nothing to drain, so its result is captured one cycle early.
  assign w_load_out  = ((r_state == DRAIN) && !r_prod_vld) ||
                       ((r_state == OUT) && !r_out_valid);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = (i_len != '0) ? ACC : DRAIN;
      ACC:     if (w_beat && (r_remaining == LEN_W'(1))) w_state_next = DRAIN;
      DRAIN:   w_state_next = OUT;
      OUT:     if (w_out_fire) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc       <= '0;
      r_remaining <= '0;
      r_prod      <= '0;
      r_prod_vld  <= 1'b0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_prod_vld <= w_beat;
      if (w_beat) begin
        r_prod      <= PROD_W'(i_a) * PROD_W'(i_b);
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (w_start_job) begin
        r_acc       <= ACC_W'(i_bias);
        r_remaining <= i_len;
        r_shift     <= i_shift;
      end else if (r_prod_vld) begin
        r_acc <= r_acc + ACC_W'(r_prod);
      end
      if (w_load_out) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res_data;
        r_out_sat   <= w_sat;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  mac_round_sat #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_round_sat (
    .i_acc   (r_acc),
    .i_shift (r_shift),
    .o_data  (w_sat_data),
    .o_sat   (w_sat)
  );

`ifdef MAC_DOT_RELU_EN
  logic r_relu;

  always_ff @(posedge i_clk) begin
    if (i_reset)          r_relu <= 1'b0;
    else if (w_start_job) r_relu <= i_relu;
  end

  assign w_res_data = (r_relu && w_sat_data[OUT_W-1]) ? '0 : w_sat_data;
`else
  assign w_res_data = w_sat_data;
`endif

  assign o_in_ready  = (r_state == ACC);
  assign o_busy      = (r_state != IDLE);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sat   = r_out_sat;

endmodule

// File: tb/tb_mac_dot_engine.sv
// Scoreboard bench for mac_dot_engine built with a 16-bit output so clipping is
// reachable; expected results come from a behavioural model of the arithmetic.
module tb_mac_dot_engine;

  localparam int DATA_W  = 16;
  localparam int ACC_W   = 48;
  localparam int LEN_W   = 10;
  localparam int OUT_W   = 16;
  localparam int SHIFT_W = 6;
`ifdef MAC_DOT_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic        [LEN_W-1:0]   len;
  logic signed [DATA_W-1:0]  bias;
  logic        [SHIFT_W-1:0] shift;
  logic                      relu;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  a;
  logic signed [DATA_W-1:0]  b;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_sat;
  logic                      busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mac_dot_engine #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .LEN_W   (LEN_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_len       (len),
    .i_bias      (bias),
    .i_shift     (shift),
`ifdef MAC_DOT_RELU_EN
    .i_relu      (relu),
`endif
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_sat   (out_sat),
    .o_busy      (busy)
  );

  function automatic exp_t model(longint acc, int sh, bit relu_v);
    exp_t   e;
    longint v;
    longint hi = (longint'(1) <<< (OUT_W-1)) - 1;
    longint lo = -(longint'(1) <<< (OUT_W-1));
    if (sh >= ACC_W)  v = (acc < 0) ? -1 : 0;
    else if (sh == 0) v = acc;
    else              v = (acc + (longint'(1) <<< (sh-1))) >>> sh;
    e.sat = 1'b0;
    if (v > hi) begin
      v = hi; e.sat = 1'b1;
    end else if (v < lo) begin
      v = lo; e.sat = 1'b1;
    end
    if (RELU_ON && relu_v && v < 0) v = 0;
    e.data = v;
    return e;
  endfunction

  // Starts a job, feeds its beats and pushes the model result to the scoreboard.
  task automatic drive_job(int n, int bias_v, int sh, bit relu_v, int a_v, int b_v,
                           bit bubbles, bit rnd);
    longint acc = bias_v;
    @(posedge clk); #1;
    start = 1'b1;
    len   = n[LEN_W-1:0];
    bias  = bias_v[DATA_W-1:0];
    shift = sh[SHIFT_W-1:0];
    relu  = relu_v;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      int av = a_v;
      int bv = b_v;
      if (rnd) begin
        av = int'($urandom_range(400)) - 200;
        bv = int'($urandom_range(400)) - 200;
      end
      if (bubbles && i > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      a = av[DATA_W-1:0];
      b = bv[DATA_W-1:0];
      acc += longint'(av) * longint'(bv);
      @(posedge clk); #1;
    end
    if (n > 0) in_valid = 1'b0;
    sb.push_back(model(acc, sh, relu_v));
  endtask

  // Counts edges until out_valid is seen at a falling edge (bounded).
  task automatic wait_out(output int n, output bit saw_rdy);
    n = 0;
    saw_rdy = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      if (in_ready) saw_rdy = 1'b1;
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_sat, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/vld/sat/busy=%b, want 0000",
               {in_ready, out_valid, out_sat, busy});
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d, want 0", out_data);
    end
  endtask

  task automatic test_conv();
    int   lat;
    bit   rdy;
    exp_t e;
    drive_job(25, 0, 0, 1'b0, 2, 3, 1'b0, 1'b0);
    wait_out(lat, rdy);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL conv_latency: got %0d edges after last beat, want 2", lat);
    end
    n_checks++;
    if (out_data !== e.data[OUT_W-1:0] || out_sat !== e.sat) begin
      n_fail++;
      $display("FAIL conv_result: got %0d sat=%0b, want %0d sat=%0b",
               out_data, out_sat, e.data, e.sat);
    end
    accept_out();
  endtask

  task automatic test_fc_bubbles();
    int   lat;
    bit   rdy;
    exp_t e;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_in_ready: got %b, want 0", in_ready);
    end
    drive_job(192, -100, 0, 1'b0, 1, 1, 1'b1, 1'b0);
    wait_out(lat, rdy);
    e = sb.pop_front();
    n_checks++;
    if (rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_out_in_ready: got %b, want 0", rdy);
    end
    n_checks++;
    if (out_data !== e.data[OUT_W-1:0] || out_sat !== e.sat || lat !== 2) begin
      n_fail++;
      $display("FAIL fc_result: got %0d sat=%0b lat=%0d, want %0d sat=%0b lat=2",
               out_data, out_sat, lat, e.data, e.sat);
    end
    accept_out();
  endtask

  task automatic test_round();
    int   av[5] = '{7, -7, -7, 7, 6};
    int   sv[5] = '{1, 1, 63, 63, 2};
    int   lat;
    bit   rdy;
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      drive_job(1, 0, sv[k], 1'b0, av[k], 1, 1'b0, 1'b0);
      wait_out(lat, rdy);
      e = sb.pop_front();
      n_checks++;
      if (out_data !== e.data[OUT_W-1:0] || out_sat !== e.sat) begin
        n_fail++;
        $display("FAIL round_%0d: got %0d sat=%0b, want %0d sat=%0b",
                 k, out_data, out_sat, e.data, e.sat);
      end
      accept_out();
    end
  endtask

  task automatic test_saturation();
    int   av[2] = '{32767, -32768};
    int   lat;
    bit   rdy;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      drive_job(4, 0, 0, 1'b0, av[k], 32767, 1'b0, 1'b0);
      wait_out(lat, rdy);
      e = sb.pop_front();
      n_checks++;
      if (out_data !== e.data[OUT_W-1:0] || out_sat !== e.sat) begin
        n_fail++;
        $display("FAIL sat_%0d: got %0d sat=%0b, want %0d sat=%0b",
                 k, out_data, out_sat, e.data, e.sat);
      end
      accept_out();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    bit   rdy;
    exp_t e;
    // Operand beats offered outside ACC must not reach the accumulator.
    in_valid = 1'b1;
    a = 16'sd100;
    b = 16'sd100;
    drive_job(0, 5, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_out(lat, rdy);
    in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (lat !== 1 || out_data !== e.data[OUT_W-1:0] || out_sat !== e.sat) begin
      n_fail++;
      $display("FAIL len0_result: got %0d sat=%0b lat=%0d, want %0d sat=%0b lat=1",
               out_data, out_sat, lat, e.data, e.sat);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start = (c == 4);
      len   = 10'd3;
      bias  = 16'sd99;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== e.data[OUT_W-1:0] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_%0d: got vld=%b data=%0d busy=%b, want vld=1 data=%0d busy=1",
                 c, out_valid, out_data, busy, e.data);
      end
    end
    start = 1'b0;
    accept_out();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_out_ignored: got busy=%b vld=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_job();
    int   lat;
    bit   rdy;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    len   = 10'd25;
    bias  = 16'sd0;
    shift = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 16'sd9;
      b = 16'sd9;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy/rdy/vld=%b data=%0d, want 000 data=0",
               {busy, in_ready, out_valid}, out_data);
    end
    drive_job(2, 0, 0, 1'b0, 1, 1, 1'b0, 1'b0);
    wait_out(lat, rdy);
    e = sb.pop_front();
    n_checks++;
    if (out_data !== e.data[OUT_W-1:0] || out_sat !== e.sat || lat !== 2) begin
      n_fail++;
      $display("FAIL after_reset_job: got %0d sat=%0b lat=%0d, want %0d sat=%0b lat=2",
               out_data, out_sat, lat, e.data, e.sat);
    end
    accept_out();
`ifdef MAC_DOT_RELU_EN
    drive_job(1, 0, 0, 1'b1, -3, 1, 1'b0, 1'b0);
    wait_out(lat, rdy);
    e = sb.pop_front();
    n_checks++;
    if (out_data !== e.data[OUT_W-1:0] || out_sat !== e.sat) begin
      n_fail++;
      $display("FAIL relu: got %0d sat=%0b, want %0d sat=%0b",
               out_data, out_sat, e.data, e.sat);
    end
    accept_out();
`endif
  endtask

  task automatic test_random_jobs();
    int   lat;
    bit   rdy;
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      drive_job(int'($urandom_range(8, 1)), int'($urandom_range(2000)) - 1000,
                int'($urandom_range(10)), 1'b0, 0, 0, j[0], 1'b1);
      wait_out(lat, rdy);
      e = sb.pop_front();
      n_checks++;
      if (out_data !== e.data[OUT_W-1:0] || out_sat !== e.sat || lat !== 2) begin
        n_fail++;
        $display("FAIL random_%0d: got %0d sat=%0b lat=%0d, want %0d sat=%0b lat=2",
                 j, out_data, out_sat, lat, e.data, e.sat);
      end
      accept_out();
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    bias      = '0;
    shift     = '0;
    relu      = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    test_reset();
    test_conv();
    test_fc_bubbles();
    test_round();
    test_saturation();
    test_backpressure();
    test_reset_mid_job();
    test_random_jobs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
